// File: rtl/bidir_reg_io.sv
// Per-bit bidirectional pin driver for one daughterboard I/O bank: OE register
// written over the serial control bus with a bit mask, plus a 2-flop pin readback.
`timescale 1ns/1ps
module bidir_reg_io #(
  parameter int         WIDTH   = 16,
  parameter logic [6:0] OE_ADDR = 7'd20
) (
  input  logic             clock,
  input  logic             reset_n,
  inout  wire  [WIDTH-1:0] tristate,
  input  logic [WIDTH-1:0] reg_val,
  input  logic [6:0]       serial_addr,
  input  logic [31:0]      serial_data,
  input  logic             serial_strobe,
  output logic [WIDTH-1:0] oe,
  output logic [WIDTH-1:0] pin_in
);

  logic [WIDTH-1:0] oe_q, oe_d;
  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] pin_in_q;
  logic             write_hit;
  logic [WIDTH-1:0] wr_mask;
  logic [WIDTH-1:0] wr_val;

  // Upper half of the serial word is the mask, lower half the new OE bits.
  assign wr_mask   = serial_data[16 +: WIDTH];
  assign wr_val    = serial_data[WIDTH-1:0];
  assign write_hit = serial_strobe && (serial_addr == OE_ADDR);

  always_comb begin
    oe_d = oe_q;
    if (write_hit) begin
      oe_d = (oe_q & ~wr_mask) | (wr_val & wr_mask);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      oe_q     <= '0;
      sync1_q  <= '0;
      pin_in_q <= '0;
    end else begin
      oe_q     <= oe_d;
      sync1_q  <= tristate;
      pin_in_q <= sync1_q;
    end
  end

  // Pin drive is purely combinational so reg_val reaches the pins with no latency.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pin
      assign tristate[gi] = oe_q[gi] ? reg_val[gi] : 1'bz;
    end
  endgenerate

  assign oe     = oe_q;
  assign pin_in = pin_in_q;

endmodule

// File: tb/tb_bidir_reg_io.sv
// Bench for bidir_reg_io: directed scenarios plus random serial writes, checked
// against a mask/merge model of the OE register and a two-stage pin history.
`timescale 1ns/1ps
module tb_bidir_reg_io;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] reg_val = '0;
  logic [6:0]  serial_addr = '0;
  logic [31:0] serial_data = '0;
  logic        serial_strobe = 1'b0;
  logic [15:0] oe;
  logic [15:0] pin_in;
  wire  [15:0] pins;

  // External world: drives only the pins the model says are released.
  logic [15:0] ext_en = '1;
  logic [15:0] ext_val = '0;

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_ext
      assign pins[gi] = ext_en[gi] ? ext_val[gi] : 1'bz;
    end
  endgenerate

  bidir_reg_io #(.WIDTH(16), .OE_ADDR(7'd20)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .tristate     (pins),
    .reg_val      (reg_val),
    .serial_addr  (serial_addr),
    .serial_data  (serial_data),
    .serial_strobe(serial_strobe),
    .oe           (oe),
    .pin_in       (pin_in)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model
  logic [15:0] oe_m = '0;
  logic [15:0] s1_m = '0;
  logic [15:0] pin_in_m = '0;

  function automatic logic [15:0] level_m();
    return (oe_m & reg_val) | (~oe_m & ext_val);
  endfunction

  // Advance one rising edge: update model from inputs, then return at the falling edge.
  task automatic cycle();
    logic [15:0] lvl;
    lvl = level_m();
    if (reset_n) begin
      pin_in_m = s1_m;
      s1_m     = lvl;
      if (serial_strobe && serial_addr == 7'd20)
        oe_m = (oe_m & ~serial_data[31:16]) | (serial_data[15:0] & serial_data[31:16]);
    end
    @(posedge clock);
    #1;
    ext_en = ~oe_m;
    @(negedge clock);
  endtask

  task automatic write(input logic [6:0] a, input logic [31:0] d, input logic s);
    serial_addr = a; serial_data = d; serial_strobe = s;
    cycle();
    serial_strobe = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ext_en = '1; ext_val = 16'h0000;
    oe_m = '0; s1_m = '0; pin_in_m = '0;
    repeat (3) cycle();
    n_checks++;
    if (oe !== 16'h0000) $display("FAIL reset_oe actual=%h required=%h", oe, 16'h0000);
    else n_pass++;
    n_checks++;
    if (pin_in !== 16'h0000) $display("FAIL reset_pin_in actual=%h required=%h", pin_in, 16'h0000);
    else n_pass++;
    reset_n = 1'b1;
    ext_val = 16'hA5A5;
    #1;
    n_checks++;
    if (pins !== 16'hA5A5) $display("FAIL reset_pins_z actual=%h required=%h", pins, 16'hA5A5);
    else n_pass++;
    cycle();
    n_checks++;
    if (pin_in !== 16'h0000) $display("FAIL pull_one_clk actual=%h required=%h", pin_in, 16'h0000);
    else n_pass++;
    cycle();
    n_checks++;
    if (pin_in !== 16'hA5A5) $display("FAIL pull_two_clk actual=%h required=%h", pin_in, 16'hA5A5);
    else n_pass++;
  endtask

  task automatic test_masked_write();
    ext_val = 16'hCB00;
    write(7'd20, 32'hFFFF_00FF, 1'b1);
    n_checks++;
    if (oe !== 16'h00FF) $display("FAIL masked_write_oe actual=%h required=%h", oe, 16'h00FF);
    else n_pass++;
    reg_val = 16'h1234;
    #1;
    n_checks++;
    if (pins !== 16'hCB34) $display("FAIL masked_write_pins actual=%h required=%h", pins, 16'hCB34);
    else n_pass++;
    write(7'd20, 32'h0F00_0F0F, 1'b1);
    n_checks++;
    if (oe !== 16'h0FFF) $display("FAIL partial_mask_oe actual=%h required=%h", oe, 16'h0FFF);
    else n_pass++;
  endtask

  task automatic test_ignored_writes();
    write(7'd21, 32'hFFFF_FFFF, 1'b1);
    n_checks++;
    if (oe !== 16'h0FFF) $display("FAIL ignore_addr actual=%h required=%h", oe, 16'h0FFF);
    else n_pass++;
    write(7'd20, 32'hFFFF_0000, 1'b0);
    n_checks++;
    if (oe !== 16'h0FFF) $display("FAIL ignore_nostrobe actual=%h required=%h", oe, 16'h0FFF);
    else n_pass++;
    write(7'd20, 32'h0000_FFFF, 1'b1);
    n_checks++;
    if (oe !== 16'h0FFF) $display("FAIL ignore_mask0 actual=%h required=%h", oe, 16'h0FFF);
    else n_pass++;
    // Held strobe re-applies the same write every cycle.
    serial_addr = 7'd20; serial_data = 32'h00F0_0000; serial_strobe = 1'b1;
    repeat (3) cycle();
    serial_strobe = 1'b0;
    n_checks++;
    if (oe !== 16'h0F0F) $display("FAIL held_strobe actual=%h required=%h", oe, 16'h0F0F);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    write(7'd20, 32'hFFFF_FFFF, 1'b1);
    reg_val = 16'h5AA5; ext_val = 16'h3C3C;
    cycle();
    #2;
    reset_n = 1'b0; ext_en = '1;
    oe_m = '0; s1_m = '0; pin_in_m = '0;
    #1;
    n_checks++;
    if (oe !== 16'h0000) $display("FAIL async_reset_oe actual=%h required=%h", oe, 16'h0000);
    else n_pass++;
    n_checks++;
    if (pins !== 16'h3C3C) $display("FAIL async_reset_pins actual=%h required=%h", pins, 16'h3C3C);
    else n_pass++;
    n_checks++;
    if (pin_in !== 16'h0000) $display("FAIL async_reset_pin_in actual=%h required=%h", pin_in, 16'h0000);
    else n_pass++;
    @(negedge clock);
    write(7'd20, 32'hFFFF_FFFF, 1'b1);
    n_checks++;
    if (oe !== 16'h0000) $display("FAIL strobe_in_reset actual=%h required=%h", oe, 16'h0000);
    else n_pass++;
    reset_n = 1'b1;
    write(7'd20, 32'h0003_0001, 1'b1);
    n_checks++;
    if (oe !== 16'h0001) $display("FAIL first_write_after_reset actual=%h required=%h", oe, 16'h0001);
    else n_pass++;
  endtask

  task automatic test_readback();
    write(7'd20, 32'hFFFF_FFFF, 1'b1);
    reg_val = 16'h0000;
    repeat (2) cycle();
    @(posedge clock);
    #1;
    reg_val = 16'hBEEF;
    #1;
    n_checks++;
    if (pins !== 16'hBEEF) $display("FAIL readback_pins actual=%h required=%h", pins, 16'hBEEF);
    else n_pass++;
    @(negedge clock);
    n_checks++;
    if (pin_in !== 16'h0000) $display("FAIL readback_k actual=%h required=%h", pin_in, 16'h0000);
    else n_pass++;
    cycle();
    n_checks++;
    if (pin_in !== 16'h0000) $display("FAIL readback_k1 actual=%h required=%h", pin_in, 16'h0000);
    else n_pass++;
    cycle();
    n_checks++;
    if (pin_in !== 16'hBEEF) $display("FAIL readback_k2 actual=%h required=%h", pin_in, 16'hBEEF);
    else n_pass++;
    // Resync model history with the directly observed sequence.
    s1_m = 16'hBEEF; pin_in_m = 16'hBEEF;
  endtask

  task automatic test_random();
    logic [15:0] mask;
    for (int i = 0; i < 300; i++) begin
      reg_val = 16'($urandom);
      ext_val = 16'($urandom);
      serial_strobe = ($urandom_range(0, 3) != 0);
      serial_addr = ($urandom_range(0, 4) == 0) ? 7'($urandom) : 7'd20;
      mask = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      serial_data = {mask, 16'($urandom)};
      #1;
      n_checks++;
      if (pins !== level_m()) $display("FAIL rand_pins i=%0d actual=%h required=%h", i, pins, level_m());
      else n_pass++;
      cycle();
      n_checks++;
      if (oe !== oe_m) $display("FAIL rand_oe i=%0d actual=%h required=%h", i, oe, oe_m);
      else n_pass++;
      n_checks++;
      if (pin_in !== pin_in_m) $display("FAIL rand_pin_in i=%0d actual=%h required=%h", i, pin_in, pin_in_m);
      else n_pass++;
    end
    serial_strobe = 1'b0;
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_masked_write();
    test_ignored_writes();
    test_async_reset();
    test_readback();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
